// File: rtl/dram_mq_regs_pkg.sv
// Shared constants for the DRAM queue register block:
// ring widths, block tag, register map and address fields.
package dram_mq_regs_pkg;

  localparam int CPCI_NF2_DATA_WIDTH       = 32;
  localparam int UDP_REG_ADDR_WIDTH        = 23;
  localparam int DRAM_QUEUE_REG_ADDR_WIDTH = 8;
  localparam int DRAM_QUEUE_BLOCK_ADDR     = 'h0004;

  localparam int REG_IDX_LSB = 0;
  localparam int REG_IDX_W   = 3;
  localparam int QUEUE_LSB   = 3;
  localparam int CNT_NUM     = 5;

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_BLK  = 3'd1;
  localparam logic [2:0] REG_SC   = 3'd2;
  localparam logic [2:0] REG_IN   = 3'd3;
  localparam logic [2:0] REG_OUT  = 3'd4;
  localparam logic [2:0] REG_DWR  = 3'd5;
  localparam logic [2:0] REG_DRD  = 3'd6;
  localparam logic [2:0] REG_RSVD = 3'd7;

  localparam logic [31:0] INVALID_RD = 32'hDEADBEEF;

endpackage

// File: rtl/dram_mq_regs_cntr.sv
// Per-queue word counter: free-running add, load on write,
// optional clear-on-read (keeps the same-cycle increment).
module dram_mq_cntr #(
  parameter int INC_WIDTH     = 4,
  parameter int CNTR_WIDTH    = 32,
  parameter int RESET_ON_READ = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INC_WIDTH-1:0]  inc,
  input  logic                  ld,
  input  logic [CNTR_WIDTH-1:0] ld_val,
  input  logic                  rd,
  output logic [CNTR_WIDTH-1:0] value
);

  logic [CNTR_WIDTH-1:0] inc_ext;
  assign inc_ext = CNTR_WIDTH'(inc);

  always_ff @(posedge clk) begin
    if (reset)
      value <= '0;
    else if (ld)
      value <= ld_val + inc_ext;
    else if (rd && RESET_ON_READ != 0)
      value <= inc_ext;
    else
      value <= value + inc_ext;
  end

endmodule

// File: rtl/dram_mq_regs.sv
// Register-ring slave for the DRAM queues: per-queue control,
// block count and five word counters behind one tag.
module dram_mq_regs
  import dram_mq_regs_pkg::*;
#(
  parameter int UDP_REG_SRC_WIDTH     = 2,
  parameter int NUM_QUEUES            = 8,
  parameter int QUEUE_IDX_WIDTH       = 3,
  parameter int DRAM_BLOCK_ADDR_WIDTH = 3,
  parameter int INC_WIDTH             = 4,
  parameter int CNTR_WIDTH            = 32,
  parameter int RESET_ON_READ         = 0,
  parameter int TAG                   = DRAM_QUEUE_BLOCK_ADDR,
  parameter int REG_ADDR_WIDTH        = DRAM_QUEUE_REG_ADDR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  reg_req_in,
  input  logic                                  reg_ack_in,
  input  logic                                  reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]         reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0]        reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]          reg_src_in,
  output logic                                  reg_req_out,
  output logic                                  reg_ack_out,
  output logic                                  reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]         reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0]        reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]          reg_src_out,
  output logic [NUM_QUEUES-1:0]                 shortcut_disable,
  output logic [NUM_QUEUES*DRAM_BLOCK_ADDR_WIDTH-1:0] block_num,
  input  logic [NUM_QUEUES*INC_WIDTH-1:0]       shortcut_words,
  input  logic [NUM_QUEUES*INC_WIDTH-1:0]       input_words,
  input  logic [NUM_QUEUES*INC_WIDTH-1:0]       output_words,
  input  logic [NUM_QUEUES*INC_WIDTH-1:0]       dram_wr_words,
  input  logic [NUM_QUEUES*INC_WIDTH-1:0]       dram_rd_words
);

  localparam int DW = CPCI_NF2_DATA_WIDTH;
  localparam int AW = UDP_REG_ADDR_WIDTH;
  localparam int TW = AW - REG_ADDR_WIDTH;
  localparam int BW = DRAM_BLOCK_ADDR_WIDTH;
  localparam int QW = QUEUE_IDX_WIDTH;

  logic [2:0]    idx;
  logic [QW-1:0] q;
  logic          claim, q_ok, rd, wr;
  logic          unused_addr;

  assign idx   = reg_addr_in[REG_IDX_LSB +: REG_IDX_W];
  assign q     = reg_addr_in[QUEUE_LSB +: QW];
  assign claim = reg_req_in && !reg_ack_in &&
                 reg_addr_in[AW-1:REG_ADDR_WIDTH] == TW'(TAG);
  assign q_ok  = {1'b0, q} < (QW+1)'(NUM_QUEUES);
  assign rd    = claim && reg_rd_wr_L_in && q_ok;
  assign wr    = claim && !reg_rd_wr_L_in && q_ok;
  assign unused_addr = ^reg_addr_in;

  logic [NUM_QUEUES-1:0] q_hit;
  always_comb begin
    q_hit = '0;
    for (int i = 0; i < NUM_QUEUES; i++)
      q_hit[i] = (q == QW'(i));
  end

  logic [NUM_QUEUES*INC_WIDTH-1:0] inc_bus [CNT_NUM];
  logic [CNTR_WIDTH-1:0]           cnt [CNT_NUM][NUM_QUEUES];

  assign inc_bus[0] = shortcut_words;
  assign inc_bus[1] = input_words;
  assign inc_bus[2] = output_words;
  assign inc_bus[3] = dram_wr_words;
  assign inc_bus[4] = dram_rd_words;

  for (genvar k = 0; k < CNT_NUM; k++) begin : g_kind
    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_q
      logic hit;
      assign hit = q_hit[i] && idx == REG_SC + 3'(k);
      dram_mq_cntr #(
        .INC_WIDTH    (INC_WIDTH),
        .CNTR_WIDTH   (CNTR_WIDTH),
        .RESET_ON_READ(RESET_ON_READ)
      ) u_cntr (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_bus[k][i*INC_WIDTH +: INC_WIDTH]),
        .ld    (wr && hit),
        .ld_val(reg_data_in[CNTR_WIDTH-1:0]),
        .rd    (rd && hit),
        .value (cnt[k][i])
      );
    end
  end

  logic [NUM_QUEUES-1:0][BW-1:0] raw;
  logic                          sel_ctrl;
  logic [BW-1:0]                 sel_raw;
  logic [CNTR_WIDTH-1:0]         sel_cnt [CNT_NUM];
  logic [DW-1:0]                 rdata;

  always_comb begin
    sel_ctrl = 1'b0;
    sel_raw  = '0;
    for (int k = 0; k < CNT_NUM; k++)
      sel_cnt[k] = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (q_hit[i]) begin
        sel_ctrl = shortcut_disable[i];
        sel_raw  = raw[i];
        for (int k = 0; k < CNT_NUM; k++)
          sel_cnt[k] = cnt[k][i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (!q_ok)
      rdata = INVALID_RD;
    else
      unique case (1'b1)
        idx == REG_CTRL: rdata = DW'(sel_ctrl);
        idx == REG_BLK:  rdata = DW'(sel_raw);
        idx == REG_SC:   rdata = DW'(sel_cnt[0]);
        idx == REG_IN:   rdata = DW'(sel_cnt[1]);
        idx == REG_OUT:  rdata = DW'(sel_cnt[2]);
        idx == REG_DWR:  rdata = DW'(sel_cnt[3]);
        idx == REG_DRD:  rdata = DW'(sel_cnt[4]);
        default:         rdata = '0;
      endcase
  end

  // Raw zero means "no limit", presented downstream as all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      shortcut_disable <= '0;
      raw              <= '0;
      block_num        <= '1;
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (wr && q_hit[i] && idx == REG_CTRL)
          shortcut_disable[i] <= reg_data_in[0];
        if (wr && q_hit[i] && idx == REG_BLK) begin
          raw[i] <= reg_data_in[BW-1:0];
          block_num[i*BW +: BW] <= (reg_data_in[BW-1:0] == '0) ?
                                   '1 : reg_data_in[BW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in || claim;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_data_out    <= (claim && reg_rd_wr_L_in) ? rdata : reg_data_in;
      reg_src_out     <= reg_src_in;
    end
  end

endmodule

// File: tb/tb_dram_mq_regs.sv
// Directed bench for dram_mq_regs: ring responses go through a
// scoreboard; a second instance exercises clear-on-read.
module tb_dram_mq_regs;
  import dram_mq_regs_pkg::*;

  localparam int NQ = 8;
  localparam int IW = 4;
  localparam int BW = 3;

  logic clk = 1'b0;
  logic reset;
  logic req, ack, rdwr;
  logic [22:0] addr;
  logic [31:0] data;
  logic [1:0]  src;
  logic [NQ*IW-1:0] sc_w, in_w, out_w, dwr_w, drd_w;

  logic        o_req, o_ack, o_rdwr;
  logic [22:0] o_addr;
  logic [31:0] o_data;
  logic [1:0]  o_src;
  logic [NQ-1:0]    o_sd;
  logic [NQ*BW-1:0] o_bn;

  logic        r_req, r_ack, r_rdwr;
  logic [22:0] r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_src;
  logic [NQ-1:0]    r_sd;
  logic [NQ*BW-1:0] r_bn;

  typedef struct {
    string       name;
    logic [59:0] v;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [NQ*BW-1:0] bn_exp;
  logic [14:0] tag_v;

  always #5 clk = ~clk;

  dram_mq_regs #(.QUEUE_IDX_WIDTH(4), .RESET_ON_READ(0)) dut (
    .clk(clk), .reset(reset),
    .reg_req_in(req), .reg_ack_in(ack), .reg_rd_wr_L_in(rdwr),
    .reg_addr_in(addr), .reg_data_in(data), .reg_src_in(src),
    .reg_req_out(o_req), .reg_ack_out(o_ack),
    .reg_rd_wr_L_out(o_rdwr), .reg_addr_out(o_addr),
    .reg_data_out(o_data), .reg_src_out(o_src),
    .shortcut_disable(o_sd), .block_num(o_bn),
    .shortcut_words(sc_w), .input_words(in_w),
    .output_words(out_w), .dram_wr_words(dwr_w),
    .dram_rd_words(drd_w)
  );

  dram_mq_regs #(.QUEUE_IDX_WIDTH(4), .RESET_ON_READ(1)) dut_r (
    .clk(clk), .reset(reset),
    .reg_req_in(req), .reg_ack_in(ack), .reg_rd_wr_L_in(rdwr),
    .reg_addr_in(addr), .reg_data_in(data), .reg_src_in(src),
    .reg_req_out(r_req), .reg_ack_out(r_ack),
    .reg_rd_wr_L_out(r_rdwr), .reg_addr_out(r_addr),
    .reg_data_out(r_data), .reg_src_out(r_src),
    .shortcut_disable(r_sd), .block_num(r_bn),
    .shortcut_words(sc_w), .input_words(in_w),
    .output_words(out_w), .dram_wr_words(dwr_w),
    .dram_rd_words(drd_w)
  );

  function automatic logic [22:0] ra(input int q, input int idx);
    return {tag_v, 1'b0, 4'(q), 3'(idx)};
  endfunction

  task automatic check(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.name,
            64'({o_req, o_ack, o_rdwr, o_addr, o_data, o_src}),
            64'(e.v));
    end
  endtask

  task automatic idle();
    req  = 1'b0;
    ack  = 1'b0;
    rdwr = 1'b0;
    addr = '0;
    data = '0;
  endtask

  task automatic ring(input string name, input logic rq,
                      input logic ak, input logic rw,
                      input logic [22:0] a, input logic [31:0] d,
                      input logic exp_ack, input logic [31:0] exp_d);
    req  = rq;
    ack  = ak;
    rdwr = rw;
    addr = a;
    data = d;
    src  = src + 2'd1;
    sb.push_back('{name, {rq, exp_ack, rw, a, exp_d, src}});
    tick();
    idle();
  endtask

  initial begin
    tag_v = 15'(DRAM_QUEUE_BLOCK_ADDR);
    reset = 1'b1;
    src   = '0;
    idle();
    {sc_w, in_w, out_w, dwr_w, drd_w} = '0;
    tick();
    tick();
    check("rst_ring", 64'({o_req, o_ack, o_data}), 64'(0));
    check("rst_bn", 64'(o_bn), 64'(24'hFFFFFF));
    check("rst_sd", 64'(o_sd), 64'(0));

    reset = 1'b0;
    sc_w  = 32'h5;
    tick();
    tick();
    req  = 1'b1;
    rdwr = 1'b0;
    addr = ra(1, 1);
    data = 32'd5;
    reset = 1'b1;
    tick();
    check("rst_mid_ack", 64'({o_req, o_ack}), 64'(0));
    check("rst_mid_bn", 64'(o_bn), 64'(24'hFFFFFF));
    reset = 1'b0;
    sc_w  = '0;
    idle();
    ring("rst_cnt0", 1, 0, 1, ra(0, 2), 0, 1, 32'd0);
    ring("rst_raw0", 1, 0, 1, ra(1, 1), 0, 1, 32'd0);

    in_w = 32'h3 << 8;
    repeat (10) tick();
    in_w = '0;
    ring("rd_in_q2", 1, 0, 1, ra(2, 3), 0, 1, 32'd30);
    check("ror_rd_in_q2", 64'(r_data), 64'(30));

    ring("wr_sc_q0", 1, 0, 0, ra(0, 2), 32'd7, 1, 32'd7);
    sc_w = 32'h2;
    ring("rd_sc_q0", 1, 0, 1, ra(0, 2), 0, 1, 32'd7);
    check("ror_rd_prior", 64'(r_data), 64'(7));
    sc_w = '0;
    ring("rd_sc_q0_again", 1, 0, 1, ra(0, 2), 0, 1, 32'd9);
    check("ror_rd_cleared", 64'(r_data), 64'(2));

    ring("wr_bn_0", 1, 0, 0, ra(1, 1), 32'd0, 1, 32'd0);
    check("bn_zero_ones", 64'(o_bn), 64'(24'hFFFFFF));
    ring("wr_bn_5", 1, 0, 0, ra(1, 1), 32'd5, 1, 32'd5);
    bn_exp = '1;
    bn_exp[5:3] = 3'd5;
    check("bn_five", 64'(o_bn), 64'(bn_exp));
    ring("rd_bn_5", 1, 0, 1, ra(1, 1), 0, 1, 32'd5);
    ring("wr_ctrl_q1", 1, 0, 0, ra(1, 0), 32'd1, 1, 32'd1);
    check("sd_q1", 64'(o_sd), 64'(8'b0000_0010));
    ring("rd_ctrl_q1", 1, 0, 1, ra(1, 0), 0, 1, 32'd1);
    ring("wr_ctrl_q2", 1, 0, 0, ra(2, 0), 32'hFFFFFFFE, 1,
         32'hFFFFFFFE);
    check("sd_q2_bit0", 64'(o_sd), 64'(8'b0000_0010));
    ring("rd_ctrl_q2", 1, 0, 1, ra(2, 0), 0, 1, 32'd0);

    ring("wr_out_max", 1, 0, 0, ra(3, 4), 32'hFFFFFFFF, 1,
         32'hFFFFFFFF);
    out_w = 32'h3 << 12;
    tick();
    out_w = '0;
    ring("rd_out_wrap", 1, 0, 1, ra(3, 4), 0, 1, 32'd2);
    ring("rd_out_keep", 1, 0, 1, ra(3, 4), 0, 1, 32'd2);
    dwr_w = 32'h4 << 12;
    ring("wr_dwr_100", 1, 0, 0, ra(3, 5), 32'd100, 1, 32'd100);
    dwr_w = '0;
    ring("rd_dwr_104", 1, 0, 1, ra(3, 5), 0, 1, 32'd104);

    ring("tag_miss", 1, 0, 1, {15'h7FF0, 8'h13}, 32'h1234, 0,
         32'h1234);
    ring("ack_in_pass", 1, 1, 1, ra(2, 3), 32'hAAAA, 1, 32'hAAAA);
    ring("no_req_pass", 0, 0, 1, ra(0, 2), 32'h55, 0, 32'h55);
    ring("rd_q9", 1, 0, 1, ra(9, 2), 0, 1, 32'hDEADBEEF);
    ring("wr_q9", 1, 0, 0, ra(9, 1), 32'd3, 1, 32'd3);
    check("bn_after_q9", 64'(o_bn), 64'(bn_exp));
    ring("wr_rsvd", 1, 0, 0, ra(0, 7), 32'h77, 1, 32'h77);
    ring("rd_rsvd", 1, 0, 1, ra(0, 7), 0, 1, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_mq_regs.md
DRAM_MQ_REGS -- requirements
Module: dram_mq_regs

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- UDP_REG_SRC_WIDTH, 2, ring source-field width
- NUM_QUEUES, 8, number of DRAM queues served
- QUEUE_IDX_WIDTH, 3, queue-index field width; 2^QUEUE_IDX_WIDTH >= NUM_QUEUES
- DRAM_BLOCK_ADDR_WIDTH, 3, per-queue block_num width
- INC_WIDTH, 4, per-queue increment width per update port
- CNTR_WIDTH, 32, counter width; <= CPCI_NF2_DATA_WIDTH
- RESET_ON_READ, 0, 1 = counter clears when read
- TAG, DRAM_QUEUE_BLOCK_ADDR, block tag
- REG_ADDR_WIDTH, DRAM_QUEUE_REG_ADDR_WIDTH, in-block address width; >= QUEUE_IDX_WIDTH+3

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock
- reset, in, 1, synchronous active-high reset
- reg_req_in / reg_ack_in / reg_rd_wr_L_in, in, 1 each, ring request, ack, read(1)/write(0)
- reg_addr_in, in, UDP_REG_ADDR_WIDTH, ring address
- reg_data_in, in, CPCI_NF2_DATA_WIDTH, ring data
- reg_src_in, in, UDP_REG_SRC_WIDTH, ring source
- reg_*_out, out, same widths as the inputs, ring outputs
- shortcut_disable, out, NUM_QUEUES, per-queue control bit
- block_num, out, NUM_QUEUES*DRAM_BLOCK_ADDR_WIDTH, per-queue block count
- shortcut_words / input_words / output_words / dram_wr_words / dram_rd_words, in, NUM_QUEUES*INC_WIDTH each, per-queue word increments for the current cycle

Function
REQ-003 The block SHALL register every ring output, with exactly 1 cycle from input to output.
REQ-004 A request SHALL be claimed when reg_req_in=1, reg_ack_in=0 and reg_addr_in[UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH]==TAG; every other request SHALL pass through unchanged.
REQ-005 In-block address decode: bits[2:0] = register index; bits[QUEUE_IDX_WIDTH+2:3] = queue q.
- 0: ctrl (bit0 = shortcut_disable), R/W
- 1: raw block_num, R/W
- 2: shortcut counter
- 3: input counter
- 4: output counter
- 5: dram_wr counter
- 6: dram_rd counter
- 7: reads 0, writes ignored
REQ-006 A claimed request SHALL be output with reg_ack_out=1 and req/rd_wr_L/addr/src unchanged. On a read, reg_data_out SHALL carry the value zero-extended; on a write, reg_data_out SHALL equal reg_data_in.
REQ-007 A claimed access with q >= NUM_QUEUES SHALL be acked; reads SHALL return 32'hDEADBEEF; writes SHALL have no effect.
REQ-008 Each counter SHALL add its INC_WIDTH field every cycle, wrapping modulo 2^CNTR_WIDTH with no saturation.
REQ-009 A write to a counter SHALL load reg_data_in[CNTR_WIDTH-1:0] plus that cycle's increment.
REQ-010 When RESET_ON_READ=1, a read SHALL return the pre-update value and the counter SHALL become that cycle's increment. When RESET_ON_READ=0, a read SHALL not alter the counter.
REQ-011 Write to ctrl SHALL store bit0 only. Write to block_num SHALL store the low DRAM_BLOCK_ADDR_WIDTH bits. Reads SHALL return the stored bits zero-extended.
REQ-012 Outputs: shortcut_disable[q] = ctrl bit0. block_num[q] = all-ones when raw==0, else raw. Both SHALL be registered and take the new value the cycle after the write.
REQ-013 Read data SHALL reflect counter state before the current cycle's increment.

Reset
REQ-014 When reset=1 at a clk edge, the following SHALL be cleared in that cycle: all ring outputs, all counters, ctrl, raw block_num and shortcut_disable. block_num outputs SHALL go to all-ones.
REQ-015 A request present during reset SHALL be dropped, and no register SHALL be written by it.

Structure
REQ-016 A shared package SHALL hold the register-index constants (0-7), the 32'hDEADBEEF invalid-read value and the address-field offsets.
REQ-017 The counter SHALL be one sub-module, dram_mq_cntr (increment, load, clear-on-read), instantiated 5*NUM_QUEUES times.

Verification
REQ-018 Read queue 2 counter 3 after 10 cycles of input_words[q2]=3 -> reg_data_out=30, ack=1, 1-cycle latency.
REQ-019 RESET_ON_READ=1 with increment 2 during the read cycle, prior value 7 -> data=7, counter=2 next cycle.
REQ-020 Write 0 to queue 1 block_num -> block_num[q1] all-ones. Write 5 -> 5. Write 1 to ctrl -> shortcut_disable[1]=1.
REQ-021 Counter at 2^CNTR_WIDTH-1 with increment 3 -> reads 2. Write 100 with concurrent increment 4 -> reads 104.
REQ-022 Tag mismatch, or ack_in=1 -> passed through unchanged after 1 cycle. Queue index 9 with NUM_QUEUES=8 -> 32'hDEADBEEF.
REQ-023 Reset asserted mid-request -> all outputs at reset values, counters 0, request not acked.
